// File: rtl/clk_div_controller.sv
// -----------------------------------------------------------------------------
// clk_div_controller
// Run/stop controller and reconfiguration sequencer for a divided slow clock.
// Produces a square wave whose half-period is (active_divisor + 1) system
// clock cycles. A new divisor offered on the valid/ready port is held in a
// one-entry pending slot. It takes effect only on a half-period boundary, or
// on the next edge while idle, so no runt pulse is ever produced. A stop
// request issued during a high phase lets that phase finish before going idle.
//
// Ports:
//   clk            system clock
//   resetn         asynchronous active-low reset
//   start          level-sampled run request, honoured only while idle
//   stop           level-sampled stop request (wins over start in idle)
//   cfg_valid      new divisor offered
//   cfg_divisor    offered divisor value
//   cfg_ready      pending slot empty; accept when cfg_valid && cfg_ready
//   clk_out        divided clock output
//   tick           one-cycle pulse coincident with each clk_out toggle
//   busy           controller is running or draining
//   active_divisor divisor currently in use
// -----------------------------------------------------------------------------
module clk_div_controller #(
  parameter int                 WIDTH         = 28,
  parameter logic [WIDTH-1:0]   RESET_DIVISOR = 28'd49_999_999
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_divisor,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] active_divisor
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_r,        state_nxt_s;
  logic [WIDTH-1:0] count_r,        count_nxt_s;
  logic             clk_out_r,      clk_out_nxt_s;
  logic             tick_r,         tick_nxt_s;
  logic             busy_r,         busy_nxt_s;
  logic [WIDTH-1:0] active_r,       active_nxt_s;
  logic [WIDTH-1:0] pend_r,         pend_nxt_s;
  logic             pend_valid_r,   pend_valid_nxt_s;
  logic             boundary_s;
  logic             accept_s;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  // State, counter, output and config registers with async reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      count_r      <= ZERO_W;
      clk_out_r    <= 1'b0;
      tick_r       <= 1'b0;
      busy_r       <= 1'b0;
      active_r     <= RESET_DIVISOR;
      pend_r       <= ZERO_W;
      pend_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      count_r      <= count_nxt_s;
      clk_out_r    <= clk_out_nxt_s;
      tick_r       <= tick_nxt_s;
      busy_r       <= busy_nxt_s;
      active_r     <= active_nxt_s;
      pend_r       <= pend_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
    end
  end

  // Next-state, counting, toggle and pending-divisor sequencing.
  always_comb begin
    state_nxt_s      = state_r;
    count_nxt_s      = count_r;
    clk_out_nxt_s    = clk_out_r;
    tick_nxt_s       = 1'b0;
    active_nxt_s     = active_r;
    pend_nxt_s       = pend_r;
    pend_valid_nxt_s = pend_valid_r;
    boundary_s       = (count_r == active_r);
    // cfg_ready is simply the registered complement of pend_valid_r.
    accept_s         = cfg_valid && !pend_valid_r;

    case (state_r)
      IDLE: begin
        count_nxt_s   = ZERO_W;
        clk_out_nxt_s = 1'b0;
        if (pend_valid_r) begin
          active_nxt_s     = pend_r;
          pend_valid_nxt_s = 1'b0;
        end else begin
          active_nxt_s     = active_r;
        end
        if (start && !stop) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (stop && !clk_out_r) begin
          // Low phase: stop immediately, output is already at rest.
          state_nxt_s = IDLE;
          count_nxt_s = ZERO_W;
        end else if (boundary_s) begin
          count_nxt_s   = ZERO_W;
          clk_out_nxt_s = !clk_out_r;
          tick_nxt_s    = 1'b1;
          if (pend_valid_r) begin
            active_nxt_s     = pend_r;
            pend_valid_nxt_s = 1'b0;
          end else begin
            active_nxt_s     = active_r;
          end
          // Stop landing on the edge that ends a high phase: the falling
          // toggle happening now completes the drain, so go straight idle.
          if (stop) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          count_nxt_s = count_r + ONE_W;
          if (stop) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = RUN;
          end
        end
      end
      DRAIN: begin
        if (boundary_s) begin
          count_nxt_s   = ZERO_W;
          clk_out_nxt_s = 1'b0;
          tick_nxt_s    = 1'b1;
          state_nxt_s   = IDLE;
          if (pend_valid_r) begin
            active_nxt_s     = pend_r;
            pend_valid_nxt_s = 1'b0;
          end else begin
            active_nxt_s     = active_r;
          end
        end else begin
          count_nxt_s = count_r + ONE_W;
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        count_nxt_s   = ZERO_W;
        clk_out_nxt_s = 1'b0;
      end
    endcase

    // Accept only happens with the slot empty, so it never races an apply.
    if (accept_s) begin
      pend_nxt_s       = cfg_divisor;
      pend_valid_nxt_s = 1'b1;
    end else begin
      pend_nxt_s       = pend_nxt_s;
    end

    busy_nxt_s = (state_nxt_s != IDLE);
  end

  assign cfg_ready      = !pend_valid_r;
  assign clk_out        = clk_out_r;
  assign tick           = tick_r;
  assign busy           = busy_r;
  assign active_divisor = active_r;

endmodule

// File: tb/tb_clk_div_controller.sv
module tb_clk_div_controller;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic [27:0] cfg_divisor;
  logic        cfg_ready;
  logic        clk_out;
  logic        tick;
  logic        busy;
  logic [27:0] active_divisor;

  int checks   = 0;
  int failures = 0;

  clk_div_controller dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .stop           (stop),
    .cfg_valid      (cfg_valid),
    .cfg_divisor    (cfg_divisor),
    .cfg_ready      (cfg_ready),
    .clk_out        (clk_out),
    .tick           (tick),
    .busy           (busy),
    .active_divisor (active_divisor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: "running", "draining", output level, number of edges
  // elapsed in the current half-period, and a one-deep config mailbox.
  bit          m_run, m_drain, m_level, m_tick, m_pend_v;
  logic [27:0] m_act, m_pend;
  int          m_el;

  logic [31:0] exp_q[$];

  function automatic void model_reset();
    m_run = 0; m_drain = 0; m_level = 0; m_tick = 0; m_pend_v = 0;
    m_act = 28'd49_999_999; m_pend = 28'd0; m_el = 0;
  endfunction

  function automatic void model_apply();
    if (m_pend_v) begin
      m_act = m_pend;
      m_pend_v = 0;
    end
  endfunction

  function automatic void model_step(bit st, bit sp, bit cv, logic [27:0] cd);
    bit accept;
    accept = cv && !m_pend_v;
    m_tick = 0;
    if (!m_run) begin
      m_level = 0;
      model_apply();
      if (st && !sp) begin
        m_run = 1; m_drain = 0; m_el = 0;
      end
    end else if (sp && !m_drain && !m_level) begin
      m_run = 0; m_el = 0;
    end else begin
      m_el++;
      // A half-period lasts (divisor + 1) edges.
      if (m_el == int'(m_act) + 1) begin
        m_level = !m_level;
        m_tick = 1;
        m_el = 0;
        model_apply();
        if (m_drain || sp) begin
          m_run = 0; m_drain = 0;
        end
      end else if (sp) begin
        m_drain = 1;
      end
    end
    if (accept) begin
      m_pend = cd;
      m_pend_v = 1;
    end
  endfunction

  task automatic cycle(input bit st, input bit sp, input bit cv, input logic [27:0] cd);
    start = st; stop = sp; cfg_valid = cv; cfg_divisor = cd;
    @(posedge clk);
    model_step(st, sp, cv, cd);
    exp_q.push_back({m_level, m_tick, m_run, !m_pend_v, m_act});
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 28'd0);
  endtask

  // Advance until the model reaches the given level / elapsed count.
  task automatic wait_phase(input bit lvl, input int el, input string name);
    int guard;
    guard = 0;
    while (!(m_run && m_level == lvl && m_el == el) && guard < 300) begin
      cycle(1'b0, 1'b0, 1'b0, 28'd0);
      guard++;
    end
    if (guard >= 300) begin
      checks++; failures++;
      $display("FAIL wait_%s: phase not reached within 300 cycles", name);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({clk_out, tick, busy, cfg_ready, active_divisor} !== {1'b0, 1'b0, 1'b0, 1'b1, 28'd49_999_999}) begin
      failures++;
      $display("FAIL %s: got clk_out=%0b tick=%0b busy=%0b cfg_ready=%0b active=%0d, want 0 0 0 1 49999999",
               name, clk_out, tick, busy, cfg_ready, active_divisor);
    end
  endtask

  // Monitor: compare every presented output cycle against the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({clk_out, tick, busy, cfg_ready, active_divisor} !== e) begin
          failures++;
          $display("FAIL cycle_out @%0t: got clk_out=%0b tick=%0b busy=%0b cfg_ready=%0b active=%0d, want %0b %0b %0b %0b %0d",
                   $time, clk_out, tick, busy, cfg_ready, active_divisor,
                   e[31], e[30], e[29], e[28], e[27:0]);
        end
      end
    end
  end

  initial begin
    int guard;
    start = 0; stop = 0; cfg_valid = 0; cfg_divisor = 28'd0;
    resetn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    @(negedge clk); #1;
    resetn = 1'b1;

    // Divisor 2 configured while idle, then start.
    cycle(1'b0, 1'b0, 1'b1, 28'd2);
    cycle(1'b0, 1'b0, 1'b0, 28'd0);
    cycle(1'b1, 1'b0, 1'b0, 28'd0);
    idle_cycles(12);

    // Offer divisor 4 part-way through a high phase.
    wait_phase(1'b1, 1, "div4_offer");
    cycle(1'b0, 1'b0, 1'b1, 28'd4);
    idle_cycles(16);

    // Stop in a low phase, then run with divisor 0.
    wait_phase(1'b0, 0, "low_stop");
    cycle(1'b0, 1'b1, 1'b1, 28'd0);
    idle_cycles(2);
    cycle(1'b1, 1'b0, 1'b0, 28'd0);
    idle_cycles(6);
    wait_phase(1'b1, 0, "div0_high");
    cycle(1'b0, 1'b1, 1'b0, 28'd0);
    idle_cycles(3);

    // Divisor 9: stop four cycles into a high phase.
    cycle(1'b0, 1'b0, 1'b1, 28'd9);
    idle_cycles(1);
    cycle(1'b1, 1'b0, 1'b0, 28'd0);
    wait_phase(1'b1, 4, "div9_high4");
    cycle(1'b0, 1'b1, 1'b0, 28'd0);
    idle_cycles(14);

    // Start and stop together while idle.
    cycle(1'b1, 1'b1, 1'b0, 28'd0);
    cycle(1'b1, 1'b1, 1'b0, 28'd0);
    idle_cycles(2);

    // Enter drain with a pending divisor, then reset asynchronously.
    cycle(1'b1, 1'b0, 1'b0, 28'd0);
    wait_phase(1'b1, 0, "drain_entry");
    cycle(1'b0, 1'b1, 1'b0, 28'd0);
    cycle(1'b1, 1'b0, 1'b1, 28'd5);
    checks++;
    if (!(m_drain && m_pend_v)) begin
      failures++;
      $display("FAIL drain_setup: model drain=%0b pend=%0b, want 1 1", m_drain, m_pend_v);
    end
    start = 0; stop = 0; cfg_valid = 0;
    @(negedge clk); #1;
    resetn = 1'b0;
    #1;
    check_reset_values("async_reset_in_drain");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_values("reset_held");
    resetn = 1'b1;

    // Randomised run/stop/config traffic with small divisors.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0, 28'($urandom_range(0, 6)));
    end
    idle_cycles(2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain_queue: %0d expectations never compared", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
